// File: rtl/matrix_result_streamer.sv
// rtl/matrix_result_streamer.sv - snapshots a result matrix on start and streams its valid elements row-major
module matrix_result_streamer #(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              error_in,
  input  logic [2:0]        result_rows,
  input  logic [2:0]        result_cols,
  input  logic [DATA_W-1:0] result [0:MAX_DIM-1][0:MAX_DIM-1],
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_row,
  output logic [2:0]        out_col,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, CHECK, SEND, FIN} state_t;

  localparam logic [2:0] DIM_MAX = 3'(MAX_DIM);

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] snap [0:MAX_DIM-1][0:MAX_DIM-1];
  logic [2:0]        snap_rows;
  logic [2:0]        snap_cols;
  logic              snap_error;
  logic              drained;
  logic              reject;
  logic              handshake;
  logic              col_wrap;
  logic [2:0]        next_row;
  logic [2:0]        next_col;
  logic              next_last;

  assign reject    = snap_error || (snap_rows == 3'd0) || (snap_cols == 3'd0) ||
                     (snap_rows > DIM_MAX) || (snap_cols > DIM_MAX);
  assign handshake = out_valid && out_ready;

  // Position of the element that follows the one currently presented.
  always_comb begin
    col_wrap  = (out_col == snap_cols - 3'd1);
    next_col  = col_wrap ? 3'd0 : out_col + 3'd1;
    next_row  = col_wrap ? out_row + 3'd1 : out_row;
    next_last = (next_row == snap_rows - 3'd1) && (next_col == snap_cols - 3'd1);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; SEND waits one extra cycle after the last handshake so
  // the output register retires the final element before done is raised.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CHECK;
      CHECK:   state_next = reject ? FIN : SEND;
      SEND:    if (drained) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Snapshot, status flags and the registered element stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < MAX_DIM; r++) begin
        for (int c = 0; c < MAX_DIM; c++) begin
          snap[r][c] <= '0;
        end
      end
      snap_rows  <= '0;
      snap_cols  <= '0;
      snap_error <= 1'b0;
      drained    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
      out_last   <= 1'b0;
    end else begin
      busy <= (state_next == CHECK) || (state_next == SEND);
      done <= (state_next == FIN);

      if (state == IDLE && start) begin
        snap       <= result;
        snap_rows  <= result_rows;
        snap_cols  <= result_cols;
        snap_error <= error_in;
        err        <= 1'b0;
      end else if (state == CHECK && reject) begin
        err <= 1'b1;
      end

      if (state == CHECK) begin
        drained <= 1'b0;
      end else if (state == SEND && handshake && out_last) begin
        drained <= 1'b1;
      end

      if (state == CHECK && !reject) begin
        out_valid <= 1'b1;
        out_data  <= snap[0][0];
        out_row   <= 3'd0;
        out_col   <= 3'd0;
        out_last  <= (snap_rows == 3'd1) && (snap_cols == 3'd1);
      end else if (state == SEND && handshake) begin
        if (out_last) begin
          out_valid <= 1'b0;
          out_data  <= '0;
          out_row   <= '0;
          out_col   <= '0;
          out_last  <= 1'b0;
        end else begin
          out_data <= snap[next_row][next_col];
          out_row  <= next_row;
          out_col  <= next_col;
          out_last <= next_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// tb/tb_matrix_result_streamer.sv - scoreboard bench for matrix_result_streamer
module tb_matrix_result_streamer;

  localparam int DATA_W = 8;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [2:0]        row;
    logic [2:0]        col;
    logic              last;
  } elem_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              error_in = 1'b0;
  logic [2:0]        result_rows = 3'd0;
  logic [2:0]        result_cols = 3'd0;
  logic [DATA_W-1:0] result [0:4][0:4];
  logic              out_ready = 1'b1;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_row;
  logic [2:0]        out_col;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              err;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    first_valid = -1;
  bit    rand_ready = 1'b0;
  elem_t exp_q[$];
  bit    done_q[$];
  elem_t mon_e;
  bit    stalled = 1'b0;
  elem_t held;

  matrix_result_streamer #(.DATA_W(DATA_W), .MAX_DIM(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .error_in(error_in),
    .result_rows(result_rows), .result_cols(result_cols), .result(result),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes a handshake or pulses done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (stalled) begin
          chk("stall_data", out_data, held.data);
          chk("stall_row", out_row, held.row);
          chk("stall_col", out_col, held.col);
          chk("stall_last", out_last, held.last);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_element: got (%0d,%0d)=%0d, expected none", out_row, out_col, out_data);
          end else begin
            mon_e = exp_q.pop_front();
            chk("data", out_data, mon_e.data);
            chk("row", out_row, mon_e.row);
            chk("col", out_col, mon_e.col);
            chk("last", out_last, mon_e.last);
          end
        end
        stalled = !out_ready;
        held = '{out_data, out_row, out_col, out_last};
      end else begin
        if (stalled) chk("valid_held", out_valid, 1);
        stalled = 1'b0;
        chk("idle_outputs", {out_data, out_row, out_col, out_last}, 0);
      end
      if (done) begin
        chk("done_busy", busy, 0);
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc);
        end else begin
          chk("err", err, done_q.pop_front());
        end
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic run_job(input int rows, input int cols, input bit errf, input bit fill,
                         input bit rand_rdy, input int exp_done, input bit mid, input bit do_reset);
    int n;
    int dcyc;
    int hs;
    bit rej;
    bit got;
    rej = errf || rows == 0 || cols == 0 || rows > 5 || cols > 5;
    @(posedge clk);
    #1;
    rand_ready = rand_rdy;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        result[r][c] = fill ? 8'(11 + r * cols + c) : 8'($urandom);
    result_rows = 3'(rows);
    result_cols = 3'(cols);
    error_in = errf;
    if (!rej)
      for (int r = 0; r < rows; r++)
        for (int c = 0; c < cols; c++)
          exp_q.push_back('{result[r][c], 3'(r), 3'(c), (r == rows - 1) && (c == cols - 1)});
    done_q.push_back(rej);
    first_valid = -1;
    start = 1'b1;
    n = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    result_rows = 3'($urandom);
    result_cols = 3'($urandom);
    error_in = 1'($urandom);
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("err_cleared", err, 0);
    got = 1'b0;
    hs = 0;
    dcyc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        dcyc = cyc;
        got = 1'b1;
        break;
      end
      if (out_valid && out_ready) hs++;
      if (mid && cyc == n + 4) begin
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++)
            result[r][c] = 8'($urandom);
        result_rows = 3'd5;
        result_cols = 3'd5;
        start = 1'b1;
      end
      if (mid && cyc == n + 5) start = 1'b0;
      if (do_reset && hs == 4) begin
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {out_valid, out_data, out_row, out_col, out_last, busy, done, err}, 0);
        exp_q.delete();
        done_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done, expected done for %0dx%0d job", rows, cols);
    end else begin
      if (exp_done >= 0) chk("done_cycle", dcyc - n, exp_done);
      chk("first_valid", first_valid - n, rej ? -1 - n : 2);
      chk("elements_left", exp_q.size(), 0);
      chk("handshakes", hs, rej ? 0 : rows * cols);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        result[r][c] = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_outputs", {out_valid, out_data, out_row, out_col, out_last, busy, done, err}, 0);
    #9;
    rst_n = 1'b1;

    run_job(2, 3, 1'b0, 1'b1, 1'b0, 9, 1'b0, 1'b0);
    run_job(5, 5, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    run_job(3, 3, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("err_held", err, 1);
    run_job(0, 4, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    run_job(6, 2, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    run_job(3, 3, 1'b0, 1'b0, 1'b0, 12, 1'b1, 1'b0);
    run_job(4, 2, 1'b0, 1'b0, 1'b0, 11, 1'b0, 1'b0);
    run_job(1, 1, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0);
    run_job(3, 3, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    run_job(5, 5, 1'b0, 1'b0, 1'b0, 28, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++)
      run_job($urandom_range(1, 5), $urandom_range(1, 5), 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
